// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the NOP control word loaded by a bubbled buffer, and counter helpers.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_MISS_WAIT = 3'd1,
        ST_FILL      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    // Width of the miss-latency down-counter (MEM_LATENCY is at most 255)
    localparam int CNT_W = 8;

    // Register 0 is hard-wired to zero, so writes to it never create a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control word a bubbled buffer loads: marked NOP, every write enable off
    typedef struct packed {
        logic is_nop;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic halt;
    } ctrl_word_t;

    localparam ctrl_word_t NOP_CTRL = '{is_nop: 1'b1, default: 1'b0};

    // Controller output bundle; en/bub bit 3 = IF/ID, 2 = ID/EX, 1 = EX/MEM, 0 = MEM/WB
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] bub;
        logic       halted;
    } hz_ctl_t;

    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    // Saturating increment for the performance counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == PERF_CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an instruction in ID that reads the destination
// of a load still sitting in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_rs_num_id,
    input  logic [4:0] i_rt_num_id,
    input  logic       i_uses_rt_id,
    input  logic [4:0] i_rd_num_ex,
    input  logic       i_mem_read_ex,
    input  logic       i_register_write_ex,
    output logic       o_load_use
);

    logic w_load_in_ex;
    logic w_src_match;

    assign w_load_in_ex = i_mem_read_ex && i_register_write_ex && (i_rd_num_ex != REG_ZERO);
    assign w_src_match  = (i_rd_num_ex == i_rs_num_id) ||
                          (i_uses_rt_id && (i_rd_num_ex == i_rt_num_id));
    assign o_load_use   = w_load_in_ex && w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the five-stage pipeline: buffer load enables, bubble
// strobes and PC enable for load-use stalls, MEM redirects, cache-miss freezes
// and halt drain.
// Optional feature: define PIPE_PERF_CNT_EN to add the stall_cycles and
// flush_count performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [4:0]  rs_num_id,
    input  logic [4:0]  rt_num_id,
    input  logic        uses_rt_id,
    input  logic [4:0]  rd_num_ex,
    input  logic        mem_read_ex,
    input  logic        register_write_ex,
    input  logic        miss_mem,
    input  logic        redirect_mem,
    input  logic        halted_mem,
    output logic        pc_enable,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        bubble_if_id,
    output logic        bubble_id_ex,
    output logic        bubble_ex_mem,
    output logic        bubble_mem_wb,
    output logic        halted,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic [2:0]  state_o
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    hz_ctl_t          w_ctl;
    logic             w_load_use;

    hazard_detect u_hazard_detect (
        .i_rs_num_id         (rs_num_id),
        .i_rt_num_id         (rt_num_id),
        .i_uses_rt_id        (uses_rt_id),
        .i_rd_num_ex         (rd_num_ex),
        .i_mem_read_ex       (mem_read_ex),
        .i_register_write_ex (register_write_ex),
        .o_load_use          (w_load_use)
    );

    // State and miss-latency counter registers; reset aborts any stall in progress
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and enable/bubble decode; in RUN the priority is
    // miss > halt > redirect > load-use
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ctl       = '0;
        case (r_state)
            ST_RUN: begin
                if (miss_mem) begin
                    // Freeze everything; MEM/WB takes a bubble so WB retires nothing twice
                    w_state_nxt = ST_MISS_WAIT;
                    w_cnt_nxt   = LAT_M1;
                    w_ctl.bub   = 4'b0001;
                end else if (halted_mem) begin
                    // Squash younger instructions, let the halt move on to WB
                    w_state_nxt = ST_DRAIN;
                    w_ctl.en    = 4'b1111;
                    w_ctl.bub   = 4'b1110;
                end else if (redirect_mem) begin
                    // PC takes the target; the three younger slots become NOPs.
                    // A coincident load-use is moot since its consumer is squashed.
                    w_ctl.pc_en = 1'b1;
                    w_ctl.en    = 4'b1111;
                    w_ctl.bub   = 4'b1110;
                end else if (w_load_use) begin
                    // Hold PC and IF/ID, drop a bubble into EX while the load advances
                    w_ctl.en    = 4'b0111;
                    w_ctl.bub   = 4'b0100;
                end else begin
                    w_ctl.pc_en = 1'b1;
                    w_ctl.en    = 4'b1111;
                end
            end
            ST_MISS_WAIT: begin
                w_ctl.bub = 4'b0001;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_FILL: begin
                w_ctl.bub   = 4'b0001;
                w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                w_ctl.en    = 4'b0001;
                w_state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                w_ctl.halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Everything is held quiet while reset is asserted
    assign pc_enable     = rst_b & w_ctl.pc_en;
    assign en_if_id      = rst_b & w_ctl.en[3];
    assign en_id_ex      = rst_b & w_ctl.en[2];
    assign en_ex_mem     = rst_b & w_ctl.en[1];
    assign en_mem_wb     = rst_b & w_ctl.en[0];
    assign bubble_if_id  = rst_b & w_ctl.bub[3];
    assign bubble_id_ex  = rst_b & w_ctl.bub[2];
    assign bubble_ex_mem = rst_b & w_ctl.bub[1];
    assign bubble_mem_wb = rst_b & w_ctl.bub[0];
    assign halted        = rst_b & w_ctl.halted;
    assign state_o       = rst_b ? r_state : ST_RUN;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_stall_inc;
    logic        w_flush_inc;

    assign w_stall_inc = !w_ctl.pc_en && (r_state != ST_HALTED);
    assign w_flush_inc = (r_state == ST_RUN) && !miss_mem && !halted_mem && redirect_mem;

    // Saturating stall-cycle and honoured-redirect counters
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_inc) begin
                r_stall_cycles <= sat_inc32(r_stall_cycles);
            end
            if (w_flush_inc) begin
                r_flush_count <= sat_inc32(r_flush_count);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (also builds with PIPE_PERF_CNT_EN).
module tb_pipeline_hazard_ctrl;

    localparam int MEM_LATENCY = 4;

    // Packed view: {state[2:0], pc, en if/id,id/ex,ex/mem,mem/wb, bub same order, halted}
    localparam logic [12:0] E_ZERO   = 13'd0;
    localparam logic [12:0] E_RUN    = {3'd0, 1'b1, 4'b1111, 4'b0000, 1'b0};
    localparam logic [12:0] E_LU     = {3'd0, 1'b0, 4'b0111, 4'b0100, 1'b0};
    localparam logic [12:0] E_RD     = {3'd0, 1'b1, 4'b1111, 4'b1110, 1'b0};
    localparam logic [12:0] E_MISS   = {3'd0, 1'b0, 4'b0000, 4'b0001, 1'b0};
    localparam logic [12:0] E_WAIT   = {3'd1, 1'b0, 4'b0000, 4'b0001, 1'b0};
    localparam logic [12:0] E_FILL   = {3'd2, 1'b0, 4'b0000, 4'b0001, 1'b0};
    localparam logic [12:0] E_HLTM   = {3'd0, 1'b0, 4'b1111, 4'b1110, 1'b0};
    localparam logic [12:0] E_DRAIN  = {3'd3, 1'b0, 4'b0001, 4'b0000, 1'b0};
    localparam logic [12:0] E_HALTED = {3'd4, 1'b0, 4'b0000, 4'b0000, 1'b1};

    logic       clk = 1'b0;
    logic       rst_b;
    logic [4:0] rs_num_id, rt_num_id, rd_num_ex;
    logic       uses_rt_id, mem_read_ex, register_write_ex;
    logic       miss_mem, redirect_mem, halted_mem;
    logic       pc_enable, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic       bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb;
    logic       halted;
    logic [2:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
    longint      m_stall, m_flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles left frozen after a miss, drain pending, halted
    int m_frz   = 0;
    bit m_drain = 1'b0;
    bit m_hlt   = 1'b0;

    logic [12:0] w_got;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_LATENCY(MEM_LATENCY)) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .rs_num_id         (rs_num_id),
        .rt_num_id         (rt_num_id),
        .uses_rt_id        (uses_rt_id),
        .rd_num_ex         (rd_num_ex),
        .mem_read_ex       (mem_read_ex),
        .register_write_ex (register_write_ex),
        .miss_mem          (miss_mem),
        .redirect_mem      (redirect_mem),
        .halted_mem        (halted_mem),
        .pc_enable         (pc_enable),
        .en_if_id          (en_if_id),
        .en_id_ex          (en_id_ex),
        .en_ex_mem         (en_ex_mem),
        .en_mem_wb         (en_mem_wb),
        .bubble_if_id      (bubble_if_id),
        .bubble_id_ex      (bubble_id_ex),
        .bubble_ex_mem     (bubble_ex_mem),
        .bubble_mem_wb     (bubble_mem_wb),
        .halted            (halted),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count),
`endif
        .state_o           (state_o)
    );

    assign w_got = {state_o, pc_enable, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                    bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb, halted};

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        urt, mr, rw, redir;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [12:0] model_exp();
        bit lu;
        if (!rst_b)  return E_ZERO;
        if (m_hlt)   return E_HALTED;
        if (m_drain) return E_DRAIN;
        if (m_frz > 1)  return E_WAIT;
        if (m_frz == 1) return E_FILL;
        lu = mem_read_ex && register_write_ex && (rd_num_ex != 5'd0) &&
             ((rd_num_ex == rs_num_id) || (uses_rt_id && (rd_num_ex == rt_num_id)));
        if (miss_mem)     return E_MISS;
        if (halted_mem)   return E_HLTM;
        if (redirect_mem) return E_RD;
        if (lu)           return E_LU;
        return E_RUN;
    endfunction

    task automatic model_step();
        logic [12:0] e;
        e = model_exp();
        if (!rst_b) begin
            m_frz = 0; m_drain = 1'b0; m_hlt = 1'b0;
`ifdef PIPE_PERF_CNT_EN
            m_stall = 0; m_flush = 0;
`endif
        end else begin
`ifdef PIPE_PERF_CNT_EN
            if (!e[9] && !m_hlt) m_stall++;
            if (e == E_RD) m_flush++;
`endif
            if (m_hlt) begin
            end else if (m_drain) begin
                m_drain = 1'b0; m_hlt = 1'b1;
            end else if (m_frz > 0) begin
                m_frz--;
            end else if (miss_mem) begin
                m_frz = MEM_LATENCY + 1;
            end else if (halted_mem) begin
                m_drain = 1'b1;
            end
        end
    endtask

    // One clock: compare mid-cycle, take the edge, advance the model
    task automatic cyc(input string name, input bit use_model, input logic [12:0] exp_c);
        logic [12:0] e;
        @(negedge clk);
        e = use_model ? model_exp() : exp_c;
        check(name, {19'd0, w_got}, {19'd0, e});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        rs_num_id = 5'd0; rt_num_id = 5'd0; rd_num_ex = 5'd0;
        uses_rt_id = 1'b0; mem_read_ex = 1'b0; register_write_ex = 1'b0;
        miss_mem = 1'b0; redirect_mem = 1'b0; halted_mem = 1'b0;
    endtask

    task automatic rnd_inputs();
        rs_num_id = 5'($urandom_range(0, 3));
        rt_num_id = 5'($urandom_range(0, 3));
        rd_num_ex = 5'($urandom_range(0, 3));
        uses_rt_id = 1'($urandom_range(0, 1));
        mem_read_ex = 1'($urandom_range(0, 1));
        register_write_ex = 1'($urandom_range(0, 1));
        miss_mem = ($urandom_range(0, 15) == 0);
        redirect_mem = ($urandom_range(0, 7) == 0);
        halted_mem = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        rst_b = 1'b0;
        clr();

        tbl[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, E_RUN};
        tbl[1] = '{5'd8,  5'd0,  5'd8,  1'b0, 1'b1, 1'b1, 1'b0, E_LU};
        tbl[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, E_RUN};
        tbl[3] = '{5'd1,  5'd9,  5'd9,  1'b1, 1'b1, 1'b1, 1'b0, E_LU};
        tbl[4] = '{5'd1,  5'd9,  5'd9,  1'b0, 1'b1, 1'b1, 1'b0, E_RUN};
        tbl[5] = '{5'd8,  5'd0,  5'd8,  1'b0, 1'b0, 1'b1, 1'b0, E_RUN};
        tbl[6] = '{5'd8,  5'd0,  5'd8,  1'b0, 1'b1, 1'b0, 1'b0, E_RUN};
        tbl[7] = '{5'd8,  5'd0,  5'd8,  1'b0, 1'b1, 1'b1, 1'b1, E_RD};
        tbl[8] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, E_LU};

        // Reset holds everything low
        cyc("reset0", 1'b0, E_ZERO);
        cyc("reset1", 1'b0, E_ZERO);
        rst_b = 1'b1;

        // Single-cycle RUN responses
        for (int i = 0; i < 9; i++) begin
            clr();
            rs_num_id = tbl[i].rs; rt_num_id = tbl[i].rt; rd_num_ex = tbl[i].rd;
            uses_rt_id = tbl[i].urt; mem_read_ex = tbl[i].mr;
            register_write_ex = tbl[i].rw; redirect_mem = tbl[i].redir;
            cyc($sformatf("vec%0d", i), 1'b0, tbl[i].exp);
        end

        // Load-use stalls exactly one cycle
        clr(); rd_num_ex = 5'd8; rs_num_id = 5'd8; mem_read_ex = 1'b1; register_write_ex = 1'b1;
        cyc("lu_stall", 1'b0, E_LU);
        clr();
        cyc("lu_after", 1'b0, E_RUN);

        // Cache miss: 1 + MEM_LATENCY + 1 frozen cycles; events ignored while frozen
        miss_mem = 1'b1;
        cyc("miss_cycle", 1'b0, E_MISS);
        for (int i = 0; i < MEM_LATENCY; i++) begin
            miss_mem = 1'b1; redirect_mem = 1'b1; halted_mem = 1'b1;
            cyc($sformatf("miss_wait%0d", i), 1'b0, E_WAIT);
        end
        clr();
        cyc("miss_fill", 1'b0, E_FILL);
        cyc("miss_done", 1'b0, E_RUN);

        // Redirect wins over load-use; no stall afterwards
        rd_num_ex = 5'd8; rs_num_id = 5'd8; mem_read_ex = 1'b1; register_write_ex = 1'b1;
        redirect_mem = 1'b1;
        cyc("rd_lu", 1'b0, E_RD);
        clr();
        cyc("rd_after", 1'b0, E_RUN);

        // Halt: drain, then halted until reset
        halted_mem = 1'b1;
        cyc("halt_cycle", 1'b0, E_HLTM);
        cyc("halt_drain", 1'b0, E_DRAIN);
        for (int i = 0; i < 20; i++) begin
            rnd_inputs();
            cyc($sformatf("halted%0d", i), 1'b0, E_HALTED);
        end
        clr(); rst_b = 1'b0;
        cyc("halt_reset", 1'b0, E_ZERO);
        rst_b = 1'b1;
        cyc("halt_exit", 1'b0, E_RUN);

        // Reset in the middle of MISS_WAIT leaves no residual stall
        miss_mem = 1'b1;
        cyc("rm_miss", 1'b0, E_MISS);
        clr();
        cyc("rm_wait0", 1'b0, E_WAIT);
        cyc("rm_wait1", 1'b0, E_WAIT);
        rst_b = 1'b0;
        cyc("rm_reset", 1'b0, E_ZERO);
        rst_b = 1'b1;
`ifdef PIPE_PERF_CNT_EN
        check("rm_stall_cnt", stall_cycles, 32'd0);
`endif
        cyc("rm_run", 1'b0, E_RUN);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rnd_inputs();
            rst_b = ($urandom_range(0, 99) != 0);
            cyc($sformatf("rnd%0d", i), 1'b1, 13'd0);
        end
`ifdef PIPE_PERF_CNT_EN
        check("stall_cycles", stall_cycles, 32'(m_stall));
        check("flush_count", flush_count, 32'(m_flush));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
